// File: rtl/rob_pkg.sv
// Shared definitions for the reorder buffer: instruction kinds, field widths and
// small decode helpers used at retire time.
package rob_pkg;

    localparam int KIND_W = 3;
    localparam int RD_W   = 5;

    typedef enum logic [KIND_W-1:0] {
        KIND_ALU    = 3'd0,
        KIND_LOAD   = 3'd1,
        KIND_STORE  = 3'd2,
        KIND_BRANCH = 3'd3,
        KIND_JALR   = 3'd4,
        KIND_JAL    = 3'd5
    } kind_e;

    // Control transfers whose actual next PC is checked against the prediction.
    function automatic logic kind_is_ctrl(input logic [KIND_W-1:0] k);
        return (k == KIND_BRANCH) || (k == KIND_JALR);
    endfunction

    function automatic logic kind_writes_rd(input logic [KIND_W-1:0] k, input logic [RD_W-1:0] rd);
        return (k != KIND_STORE) && (k != KIND_BRANCH) && (rd != '0);
    endfunction

endpackage

// File: rtl/rob_bypass.sv
// One operand lookup: a completed entry wins, otherwise the lowest-index writeback
// port carrying the same tag this cycle supplies the value.
module rob_bypass #(
    parameter int DEPTH    = 16,
    parameter int IDX_W    = $clog2(DEPTH),
    parameter int XLEN     = 32,
    parameter int WB_PORTS = 2
) (
    input  logic [IDX_W-1:0]          q_tag_i,
    input  logic [DEPTH-1:0]          ready_i,
    input  logic [XLEN-1:0]           ent_val_i [DEPTH],
    input  logic [WB_PORTS-1:0]       wb_valid_i,
    input  logic [WB_PORTS*IDX_W-1:0] wb_tag_i,
    input  logic [WB_PORTS*XLEN-1:0]  wb_val_i,
    output logic                      hit_o,
    output logic [XLEN-1:0]           val_o
);

    always_comb begin
        hit_o = 1'b0;
        val_o = '0;
        if (ready_i[q_tag_i]) begin
            hit_o = 1'b1;
            val_o = ent_val_i[q_tag_i];
        end else begin
            // Walk from the highest port down so the lowest matching port is written last.
            for (int p = WB_PORTS - 1; p >= 0; p--) begin
                if (wb_valid_i[p] && (wb_tag_i[p*IDX_W +: IDX_W] == q_tag_i)) begin
                    hit_o = 1'b1;
                    val_o = wb_val_i[p*XLEN +: XLEN];
                end
            end
        end
    end

endmodule

// File: rtl/reorder_buf.sv
// Parametrised reorder buffer: in-order allocate and retire, out-of-order writeback,
// two bypassed operand lookups, and a full flush on a mispredicted control transfer.
module reorder_buf import rob_pkg::*; #(
    parameter int DEPTH    = 16,
    parameter int IDX_W    = $clog2(DEPTH),
    parameter int XLEN     = 32,
    parameter int WB_PORTS = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      alloc_valid,
    output logic                      alloc_ready,
    output logic [IDX_W-1:0]          alloc_tag,
    input  logic [KIND_W-1:0]         alloc_kind,
    input  logic [RD_W-1:0]           alloc_rd,
    input  logic                      alloc_done,
    input  logic [XLEN-1:0]           alloc_val,
    input  logic [XLEN-1:0]           alloc_pred,
    input  logic [WB_PORTS-1:0]       wb_valid,
    input  logic [WB_PORTS*IDX_W-1:0] wb_tag,
    input  logic [WB_PORTS*XLEN-1:0]  wb_val,
    input  logic [WB_PORTS*XLEN-1:0]  wb_npc,
    input  logic [2*IDX_W-1:0]        q_tag,
    output logic [1:0]                q_hit,
    output logic [2*XLEN-1:0]         q_val,
    output logic                      cm_valid,
    output logic [IDX_W-1:0]          cm_tag,
    output logic [RD_W-1:0]           cm_rd,
    output logic [XLEN-1:0]           cm_val,
    output logic                      cm_wen,
    output logic                      cm_store,
    output logic                      flush,
    output logic [XLEN-1:0]           flush_pc,
    output logic [IDX_W:0]            count
);

    logic [IDX_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [IDX_W:0]    count_q, count_d;
    logic [DEPTH-1:0]  vld_q, vld_d, done_q, done_d;
    logic [KIND_W-1:0] kind_q [DEPTH];
    logic [KIND_W-1:0] kind_d [DEPTH];
    logic [RD_W-1:0]   rd_q [DEPTH];
    logic [RD_W-1:0]   rd_d [DEPTH];
    logic [XLEN-1:0]   val_q [DEPTH];
    logic [XLEN-1:0]   val_d [DEPTH];
    logic [XLEN-1:0]   pred_q [DEPTH];
    logic [XLEN-1:0]   pred_d [DEPTH];
    logic [XLEN-1:0]   npc_q [DEPTH];
    logic [XLEN-1:0]   npc_d [DEPTH];

    logic              cm_valid_q, cm_wen_q, cm_store_q, flush_q;
    logic [IDX_W-1:0]  cm_tag_q;
    logic [RD_W-1:0]   cm_rd_q;
    logic [XLEN-1:0]   cm_val_q, flush_pc_q;

    logic              alloc_fire, retire, mispredict;
    logic [IDX_W-1:0]  wb_tag_a [WB_PORTS];
    logic [DEPTH-1:0]  ready_vec;

    for (genvar p = 0; p < WB_PORTS; p++) begin : g_wb_tag
        assign wb_tag_a[p] = wb_tag[p*IDX_W +: IDX_W];
    end

    // Handshake: an entry is taken on a cycle where alloc_valid && alloc_ready && rdy;
    // alloc_ready never depends on alloc_valid, and is low while full or flushing.
    assign alloc_ready = (count_q < (IDX_W+1)'(DEPTH)) && !flush_q;
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign alloc_tag   = tail_q;
    assign retire      = vld_q[head_q] && done_q[head_q];
    assign mispredict  = retire && kind_is_ctrl(kind_q[head_q]) && (npc_q[head_q] != pred_q[head_q]);
    assign ready_vec   = vld_q & done_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        vld_d   = vld_q;
        done_d  = done_q;
        kind_d  = kind_q;
        rd_d    = rd_q;
        val_d   = val_q;
        pred_d  = pred_q;
        npc_d   = npc_q;
        for (int p = WB_PORTS - 1; p >= 0; p--) begin
            if (wb_valid[p] && vld_q[wb_tag_a[p]] && !done_q[wb_tag_a[p]]) begin
                val_d[wb_tag_a[p]]  = wb_val[p*XLEN +: XLEN];
                npc_d[wb_tag_a[p]]  = wb_npc[p*XLEN +: XLEN];
                done_d[wb_tag_a[p]] = 1'b1;
            end
        end
        if (retire) begin
            vld_d[head_q] = 1'b0;
            head_d        = head_q + 1'b1;
        end
        // Allocation is applied after writeback so it owns its slot outright.
        if (alloc_fire) begin
            vld_d[tail_q]  = 1'b1;
            done_d[tail_q] = alloc_done;
            kind_d[tail_q] = alloc_kind;
            rd_d[tail_q]   = alloc_rd;
            val_d[tail_q]  = alloc_val;
            pred_d[tail_q] = alloc_pred;
            npc_d[tail_q]  = alloc_pred;
            tail_d         = tail_q + 1'b1;
        end
        case ({alloc_fire, retire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (mispredict) begin
            vld_d   = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            vld_q      <= '0;
            done_q     <= '0;
            cm_valid_q <= 1'b0;
            cm_tag_q   <= '0;
            cm_rd_q    <= '0;
            cm_val_q   <= '0;
            cm_wen_q   <= 1'b0;
            cm_store_q <= 1'b0;
            flush_q    <= 1'b0;
            flush_pc_q <= '0;
        end else if (rdy) begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            vld_q      <= vld_d;
            done_q     <= done_d;
            cm_valid_q <= retire;
            flush_q    <= mispredict;
            if (retire) begin
                cm_tag_q   <= head_q;
                cm_rd_q    <= rd_q[head_q];
                cm_val_q   <= val_q[head_q];
                cm_wen_q   <= kind_writes_rd(kind_q[head_q], rd_q[head_q]);
                cm_store_q <= (kind_q[head_q] == KIND_STORE);
            end
            if (mispredict) begin
                flush_pc_q <= npc_q[head_q];
            end
        end else begin
            cm_valid_q <= 1'b0;
            flush_q    <= 1'b0;
        end
    end

    // Payload fields are qualified by vld/done, so they need no reset.
    always_ff @(posedge clk) begin
        if (rdy) begin
            kind_q <= kind_d;
            rd_q   <= rd_d;
            val_q  <= val_d;
            pred_q <= pred_d;
            npc_q  <= npc_d;
        end
    end

    for (genvar k = 0; k < 2; k++) begin : g_lookup
        rob_bypass #(
            .DEPTH(DEPTH), .IDX_W(IDX_W), .XLEN(XLEN), .WB_PORTS(WB_PORTS)
        ) u_bypass (
            .q_tag_i    (q_tag[k*IDX_W +: IDX_W]),
            .ready_i    (ready_vec),
            .ent_val_i  (val_q),
            .wb_valid_i (wb_valid),
            .wb_tag_i   (wb_tag),
            .wb_val_i   (wb_val),
            .hit_o      (q_hit[k]),
            .val_o      (q_val[k*XLEN +: XLEN])
        );
    end

    assign cm_valid = cm_valid_q;
    assign cm_tag   = cm_tag_q;
    assign cm_rd    = cm_rd_q;
    assign cm_val   = cm_val_q;
    assign cm_wen   = cm_wen_q;
    assign cm_store = cm_store_q;
    assign flush    = flush_q;
    assign flush_pc = flush_pc_q;
    assign count    = count_q;

endmodule

// File: tb/tb_reorder_buf.sv
// Bench for reorder_buf: directed scenarios followed by random traffic, all checked
// against a queue-of-instructions reference model of the buffer.
module tb_reorder_buf;

    localparam int DEPTH = 16;
    localparam int IDX_W = 4;
    localparam int XLEN  = 32;
    localparam int WBP   = 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  rdy = 1'b1;
    logic                  alloc_valid = 1'b0;
    logic                  alloc_ready;
    logic [IDX_W-1:0]      alloc_tag;
    logic [2:0]            alloc_kind = '0;
    logic [4:0]            alloc_rd = '0;
    logic                  alloc_done = 1'b0;
    logic [XLEN-1:0]       alloc_val = '0;
    logic [XLEN-1:0]       alloc_pred = '0;
    logic [WBP-1:0]        wb_valid = '0;
    logic [WBP*IDX_W-1:0]  wb_tag = '0;
    logic [WBP*XLEN-1:0]   wb_val = '0;
    logic [WBP*XLEN-1:0]   wb_npc = '0;
    logic [2*IDX_W-1:0]    q_tag = '0;
    logic [1:0]            q_hit;
    logic [2*XLEN-1:0]     q_val;
    logic                  cm_valid;
    logic [IDX_W-1:0]      cm_tag;
    logic [4:0]            cm_rd;
    logic [XLEN-1:0]       cm_val;
    logic                  cm_wen;
    logic                  cm_store;
    logic                  flush;
    logic [XLEN-1:0]       flush_pc;
    logic [IDX_W:0]        count;

    reorder_buf dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .alloc_kind(alloc_kind), .alloc_rd(alloc_rd), .alloc_done(alloc_done),
        .alloc_val(alloc_val), .alloc_pred(alloc_pred),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_val(wb_val), .wb_npc(wb_npc),
        .q_tag(q_tag), .q_hit(q_hit), .q_val(q_val),
        .cm_valid(cm_valid), .cm_tag(cm_tag), .cm_rd(cm_rd), .cm_val(cm_val),
        .cm_wen(cm_wen), .cm_store(cm_store), .flush(flush), .flush_pc(flush_pc),
        .count(count)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: program-order list of in-flight instructions
    typedef struct {
        int          tag;
        int          kind;
        int          rd;
        bit          done;
        logic [31:0] val;
        logic [31:0] pred;
        logic [31:0] npc;
    } ment_t;

    ment_t       rob_m[$];
    logic [31:0] exp_q[$];
    int          tail_m = 0;
    bit          e_cm_valid = 0;
    bit          e_flush = 0;
    logic [31:0] e_flush_pc = '0;
    int          e_tag, e_rd;
    bit          e_wen, e_store;
    int          tests_run = 0;
    int          tests_failed = 0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    function automatic int find_m(input int tag);
        for (int i = 0; i < rob_m.size(); i++) begin
            if (rob_m[i].tag == tag) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        rob_m.delete();
        exp_q.delete();
        tail_m = 0;
        e_cm_valid = 0;
        e_flush = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        bit    accept;
        int    idx;
        ment_t e;
        ment_t n;
        if (!rdy) begin
            e_cm_valid = 0;
            e_flush = 0;
            return;
        end
        accept = alloc_valid && (rob_m.size() < DEPTH) && !e_flush;
        e_cm_valid = 0;
        e_flush = 0;
        if (rob_m.size() > 0 && rob_m[0].done) begin
            e = rob_m.pop_front();
            e_cm_valid = 1;
            e_tag = e.tag;
            e_rd = e.rd;
            e_wen = (e.kind != 2) && (e.kind != 3) && (e.rd != 0);
            e_store = (e.kind == 2);
            exp_q.push_back(e.val);
            if ((e.kind == 3 || e.kind == 4) && e.npc != e.pred) begin
                e_flush = 1;
                e_flush_pc = e.npc;
                rob_m.delete();
                tail_m = 0;
                return;
            end
        end
        for (int p = 0; p < WBP; p++) begin
            if (wb_valid[p]) begin
                idx = find_m(int'(wb_tag[p*IDX_W +: IDX_W]));
                if (idx >= 0 && !rob_m[idx].done) begin
                    n = rob_m[idx];
                    n.done = 1;
                    n.val = wb_val[p*XLEN +: XLEN];
                    n.npc = wb_npc[p*XLEN +: XLEN];
                    rob_m[idx] = n;
                end
            end
        end
        if (accept) begin
            n.tag = tail_m;
            n.kind = int'(alloc_kind);
            n.rd = int'(alloc_rd);
            n.done = alloc_done;
            n.val = alloc_val;
            n.pred = alloc_pred;
            n.npc = alloc_pred;
            rob_m.push_back(n);
            tail_m = (tail_m + 1) % DEPTH;
        end
    endtask

    task automatic q_check();
        int          tag, idx;
        bit          eh;
        logic [31:0] ev;
        for (int k = 0; k < 2; k++) begin
            tag = int'(q_tag[k*IDX_W +: IDX_W]);
            idx = find_m(tag);
            eh = 0;
            ev = '0;
            if (idx >= 0 && rob_m[idx].done) begin
                eh = 1;
                ev = rob_m[idx].val;
            end else begin
                for (int p = 0; p < WBP; p++) begin
                    if (!eh && wb_valid[p] && int'(wb_tag[p*IDX_W +: IDX_W]) == tag) begin
                        eh = 1;
                        ev = wb_val[p*XLEN +: XLEN];
                    end
                end
            end
            chk("q_hit", q_hit[k], eh);
            chk("q_val", q_val[k*XLEN +: XLEN], ev);
        end
    endtask

    // Scoreboard
    task automatic check_outputs();
        logic [31:0] v;
        chk("cm_valid", cm_valid, e_cm_valid);
        chk("flush", flush, e_flush);
        chk("count", count, rob_m.size());
        chk("alloc_ready", alloc_ready, (rob_m.size() < DEPTH) && !e_flush);
        chk("alloc_tag", alloc_tag, tail_m);
        if (e_cm_valid) begin
            v = exp_q.pop_front();
            chk("cm_val", cm_val, v);
            chk("cm_tag", cm_tag, e_tag);
            chk("cm_rd", cm_rd, e_rd);
            chk("cm_wen", cm_wen, e_wen);
            chk("cm_store", cm_store, e_store);
        end
        if (e_flush) chk("flush_pc", flush_pc, e_flush_pc);
    endtask

    // Drivers
    task automatic idle();
        alloc_valid = 1'b0;
        wb_valid = '0;
    endtask

    task automatic drive_alloc(input int kind, input int rd, input bit done,
                               input logic [31:0] val, input logic [31:0] pred);
        alloc_valid = 1'b1;
        alloc_kind = kind[2:0];
        alloc_rd = rd[4:0];
        alloc_done = done;
        alloc_val = val;
        alloc_pred = pred;
    endtask

    task automatic drive_wb(input int p, input int tag, input logic [31:0] val, input logic [31:0] npc);
        wb_valid[p] = 1'b1;
        wb_tag[p*IDX_W +: IDX_W] = tag[IDX_W-1:0];
        wb_val[p*XLEN +: XLEN] = val;
        wb_npc[p*XLEN +: XLEN] = npc;
    endtask

    task automatic step();
        #1;
        q_check();
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic drain();
        int    n;
        int    idx;
        ment_t e;
        n = 0;
        while ((rob_m.size() > 0 || e_cm_valid) && n < 300) begin
            idle();
            for (int p = 0; p < WBP; p++) begin
                if (rob_m.size() > 0) begin
                    idx = $urandom_range(0, rob_m.size() - 1);
                    e = rob_m[idx];
                    if (!e.done) drive_wb(p, e.tag, $urandom, e.pred);
                end
            end
            step();
            n++;
        end
        idle();
        chk("drain_in_budget", n < 300, 1'b1);
    endtask

    initial begin
        int          t;
        int          kind;
        int          idx;
        bit          done;
        logic [31:0] npc;
        ment_t       e;

        // Reset state
        idle();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", count, 0);
        chk("rst_cm_valid", cm_valid, 0);
        chk("rst_flush", flush, 0);
        chk("rst_cm_val", cm_val, 0);
        chk("rst_flush_pc", flush_pc, 0);
        chk("rst_q_hit", q_hit, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_alloc_ready", alloc_ready, 1);

        // Reset mid-run with five entries in flight
        for (int i = 0; i < 5; i++) begin
            drive_alloc(0, i + 1, 0, 32'h0, 32'h0);
            step();
        end
        idle();
        chk("mid_count5", count, 5);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_cm_valid", cm_valid, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rel_ready", alloc_ready, 1);
        chk("mid_rel_count", count, 0);

        // Fill to capacity, then retire the head
        for (int i = 0; i < DEPTH; i++) begin
            drive_alloc(0, i + 1, 0, 32'h0, 32'h0);
            step();
        end
        idle();
        chk("full_ready", alloc_ready, 0);
        chk("full_count", count, 16);
        drive_alloc(0, 9, 1, 32'h1234, 32'h0);
        step();
        idle();
        drive_wb(0, 0, 32'h55, 32'h0);
        step();
        idle();
        step();
        chk("t2_cm_val", cm_val, 32'h55);
        chk("t2_count", count, 15);
        drain();

        // Out-of-order writeback, in-order retire
        t = tail_m;
        for (int i = 0; i < 3; i++) begin
            drive_alloc(0, 10 + i, 0, 32'h0, 32'h0);
            step();
        end
        idle();
        drive_wb(0, (t + 2) % DEPTH, 32'h22, 32'h0);
        step();
        idle();
        drive_wb(0, (t + 1) % DEPTH, 32'h11, 32'h0);
        step();
        idle();
        drive_wb(0, t, 32'h10, 32'h0);
        step();
        idle();
        step();
        chk("t3_order0", cm_tag, t);
        step();
        chk("t3_order1", cm_tag, (t + 1) % DEPTH);
        step();
        chk("t3_order2", cm_tag, (t + 2) % DEPTH);
        chk("t3_val2", cm_val, 32'h22);

        // Both ports write one tag: port 0 wins
        t = tail_m;
        drive_alloc(0, 3, 0, 32'h0, 32'h0);
        step();
        idle();
        drive_wb(0, t, 32'hA, 32'h0);
        drive_wb(1, t, 32'hB, 32'h0);
        step();
        idle();
        step();
        chk("t4_port0_wins", cm_val, 32'hA);
        drain();

        // Mispredicted branch with three younger entries
        t = tail_m;
        drive_alloc(3, 0, 0, 32'h0, 32'h1004);
        step();
        for (int i = 0; i < 3; i++) begin
            drive_alloc(0, 20 + i, 0, 32'h0, 32'h0);
            step();
        end
        idle();
        drive_wb(0, t, 32'h0, 32'h1040);
        step();
        idle();
        step();
        chk("t5_flush", flush, 1);
        chk("t5_flush_pc", flush_pc, 32'h1040);
        chk("t5_cm_valid", cm_valid, 1);
        drive_alloc(0, 5, 0, 32'h0, 32'h0);
        step();
        idle();
        chk("t5_count0", count, 0);
        chk("t5_flush_done", flush, 0);

        // Same-cycle writeback bypass on lookup 0, plain miss on lookup 1
        for (int i = 0; i < 8; i++) begin
            drive_alloc(0, 1, 0, 32'h0, 32'h0);
            step();
        end
        idle();
        q_tag = {4'd3, 4'd7};
        drive_wb(1, 7, 32'h99, 32'h0);
        #1;
        chk("t6_hit", q_hit[0], 1);
        chk("t6_val", q_val[31:0], 32'h99);
        chk("t6_miss", q_hit[1], 0);
        step();
        idle();
        drain();

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            idle();
            rdy = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 2) != 0) begin
                kind = $urandom_range(0, 5);
                if (kind == 3 || kind == 4) done = 0;
                else if (kind == 2 || kind == 5) done = $urandom_range(0, 1);
                else done = ($urandom_range(0, 3) == 0);
                drive_alloc(kind, $urandom_range(0, 31), done, $urandom, $urandom);
            end
            for (int p = 0; p < WBP; p++) begin
                if ($urandom_range(0, 1) == 1 && rob_m.size() > 0) begin
                    idx = $urandom_range(0, rob_m.size() - 1);
                    e = rob_m[idx];
                    npc = ($urandom_range(0, 5) == 0) ? $urandom : e.pred;
                    drive_wb(p, e.tag, $urandom, npc);
                end else if ($urandom_range(0, 7) == 0) begin
                    drive_wb(p, $urandom_range(0, DEPTH - 1), $urandom, $urandom);
                end
            end
            q_tag = $urandom_range(0, 255);
            step();
        end
        rdy = 1'b1;
        idle();
        drain();

        // Final report
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
